// File: rtl/somador_multiciclo_ctrl_pkg.sv
// Shared definitions for the multi-cycle wide adder controller: FSM state encoding.
// Imported by the controller top; the chunk adder itself is state-free.
package somador_multiciclo_ctrl_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE = 2'd0,
    SOMA = 2'd1,
    FIM  = 2'd2
  } estado_t;

endpackage

// File: rtl/somador_completo_nbits.sv
// N-bit ripple-carry adder, purely combinational (zero latency, no flow control).
module somador_completo_nbits #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic carry;

  always_comb begin
    S     = '0;
    carry = Cin;
    for (int i = 0; i < N; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end

endmodule

// File: rtl/somador_multiciclo_ctrl.sv
// W=N*K bit adder time-sharing one N-bit adder over K cycles; done K+1 cycles after start, start ignored while busy.
// Optional SOMADOR_OVF_EN adds output V, the signed overflow of the final result.
module somador_multiciclo_ctrl
  import somador_multiciclo_ctrl_pkg::*;
#(
  parameter  int N = 4,
  parameter  int K = 4,
  localparam int W = N * K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         Cout
`ifdef SOMADOR_OVF_EN
  ,
  output logic         V
`endif
);

  // K >= 2 is assumed; the counter only needs to reach K-1.
  localparam int              CNT_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(K - 1);

  estado_t          state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sacc_q, sacc_d;
  logic [W-1:0]     s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SOMADOR_OVF_EN
  logic             v_q, v_d;
`endif

  logic [N-1:0] add_s;
  logic         add_cout;
  logic         carry_msb;

  somador_completo_nbits #(
    .N (N)
  ) u_somador (
    .A    (a_q[N-1:0]),
    .B    (b_q[N-1:0]),
    .Cin  (carry_q),
    .S    (add_s),
    .Cout (add_cout)
  );

  // Carry into the chunk MSB, recovered from the sum bit; only meaningful on the last chunk.
  assign carry_msb = a_q[N-1] ^ b_q[N-1] ^ add_s[N-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sacc_d  = sacc_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SOMADOR_OVF_EN
    v_d     = v_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = SOMA;
        end
      end

      SOMA: begin
        busy    = 1'b1;
        a_d     = a_q >> N;
        b_d     = b_q >> N;
        sacc_d  = {add_s, sacc_q[W-1:N]};
        carry_d = add_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == ULTIMO) begin
          state_d = FIM;
          s_d     = {add_s, sacc_q[W-1:N]};
          cout_d  = add_cout;
`ifdef SOMADOR_OVF_EN
          v_d     = carry_msb ^ add_cout;
`endif
        end
      end

      FIM: begin
        done    = 1'b1;
        state_d = IDLE;
        // Back-to-back: a start here is taken exactly as in IDLE.
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = SOMA;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sacc_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SOMADOR_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sacc_q  <= sacc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SOMADOR_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
`ifdef SOMADOR_OVF_EN
  assign V    = v_q;
`else
  // Only consumed by the overflow output.
  logic unused_carry_msb;
  assign unused_carry_msb = carry_msb;
`endif

endmodule

// File: tb/tb_somador_multiciclo_ctrl.sv
// Scoreboard bench for somador_multiciclo_ctrl with N=4, K=4.
module tb_somador_multiciclo_ctrl;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B, S;
  logic         Cin, busy, done, Cout;
`ifdef SOMADOR_OVF_EN
  logic         V;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_pulses = 0;

  always #5 clk = ~clk;

  somador_multiciclo_ctrl #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
`ifdef SOMADOR_OVF_EN
    ,
    .V     (V)
`endif
  );

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t         e;
    logic [W:0]   full;
    int           sr;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sr     = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.s    = full[W-1:0];
    e.cout = full[W];
    e.v    = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted start; optionally records the expected result.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
    A = a; B = b; Cin = cin; start = 1'b1;
    if (push) sb.push_back(model(a, b, cin));
    tick();
    start = 1'b0;
  endtask

  // Waits for done (bounded); lat = edges after the call, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; A = 16'hAAAA; B = 16'h5555; Cin = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (S !== 16'h0000) begin errors++; $display("FAIL reset_S got=%h want=0000", S); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout got=%b want=0", Cout); end
`ifdef SOMADOR_OVF_EN
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL reset_V got=%b want=0", V); end
`endif
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got=%b want=0", busy); end
  endtask

  task automatic test_basic(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string nm);
    int   lat, bc;
    exp_t e;
    launch(a, b, cin, 1'b1);
    wait_done(lat, bc);
    checks++; if (lat !== K) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, K); end
    checks++; if (bc !== K) begin errors++; $display("FAIL %s_busy_cycles got=%0d want=%0d", nm, bc, K); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_in_fim got=%b want=0", nm, busy); end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL %s_scoreboard_empty got=0 want=1", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({S, Cout} !== {e.s, e.cout}) begin
        errors++; $display("FAIL %s_result got=%h/%b want=%h/%b", nm, S, Cout, e.s, e.cout);
      end
`ifdef SOMADOR_OVF_EN
      checks++; if (V !== e.v) begin errors++; $display("FAIL %s_V got=%b want=%b", nm, V, e.v); end
`endif
      A = ~a; B = ~b;
      tick(); tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse_width got=%b want=0", nm, done); end
      checks++;
      if ({S, Cout} !== {e.s, e.cout}) begin
        errors++; $display("FAIL %s_hold_idle got=%h/%b want=%h/%b", nm, S, Cout, e.s, e.cout);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   lat, bc;
    exp_t e;
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    wait_done(lat, bc);
    checks++; if (lat !== K) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, K); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout} !== {e.s, e.cout}) begin
      errors++; $display("FAIL b2b_first got=%h/%b want=%h/%b", S, Cout, e.s, e.cout);
    end
    launch(16'h0001, 16'h0002, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble busy got=%b want=1", busy); end
    checks++; if (S !== 16'hFFFF) begin errors++; $display("FAIL b2b_hold_busy S got=%h want=ffff", S); end
    wait_done(lat, bc);
    checks++; if (lat !== K) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, K); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout} !== {e.s, e.cout}) begin
      errors++; $display("FAIL b2b_second got=%h/%b want=%h/%b", S, Cout, e.s, e.cout);
    end
    tick();
  endtask

  task automatic test_start_ignored;
    int   lat, bc, d0;
    exp_t e;
    d0 = done_pulses;
    launch(16'h1234, 16'h1111, 1'b0, 1'b1);
    tick(); tick();
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ignored_latency got=%0d want=1", lat); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout} !== {e.s, e.cout}) begin
      errors++; $display("FAIL ignored_result got=%h/%b want=%h/%b", S, Cout, e.s, e.cout);
    end
    for (int i = 0; i < K + 2; i++) tick();
    checks++;
    if (done_pulses - d0 !== 1) begin
      errors++; $display("FAIL ignored_done_count got=%0d want=1", done_pulses - d0);
    end
  endtask

  task automatic test_rst_mid;
    int   lat, bc, d0;
    exp_t e;
    d0 = done_pulses;
    launch(16'h4321, 16'h0F0F, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", done); end
    checks++;
    if ({S, Cout} !== 17'h0) begin
      errors++; $display("FAIL rstmid_result got=%h/%b want=0000/0", S, Cout);
    end
    for (int i = 0; i < K + 2; i++) tick();
    checks++;
    if (done_pulses !== d0) begin
      errors++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_pulses - d0, 0);
    end
    launch(16'h0005, 16'h0008, 1'b0, 1'b1);
    wait_done(lat, bc);
    checks++; if (lat !== K) begin errors++; $display("FAIL rstmid_fresh_latency got=%0d want=%0d", lat, K); end
    e = sb.pop_front();
    checks++;
    if ({S, Cout} !== {e.s, e.cout}) begin
      errors++; $display("FAIL rstmid_fresh got=%h/%b want=%h/%b", S, Cout, e.s, e.cout);
    end
    tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      test_basic(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    test_reset();
    test_basic(16'h00FF, 16'h0001, 1'b0, "chunk_carry");
    test_basic(16'hFFFF, 16'h0001, 1'b0, "full_ripple");
    test_back_to_back();
    test_start_ignored();
    test_rst_mid();
    test_basic(16'h7FFF, 16'h0001, 1'b0, "signed_ovf");
    test_basic(16'h8000, 16'h8000, 1'b0, "neg_ovf");
    test_random();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/somador_multiciclo_ctrl.md
Name: somador_multiciclo_ctrl

Overview:
Multi-cycle wide adder controller. It sequences a single N-bit ripple-carry adder (somador_completo_nbits) over K cycles to add two W = N*K bit operands, one N-bit chunk per cycle, LSB chunk first. The carry is held in a register between chunks. Used where a full-width combinational adder is too large or too slow; exposes a start/busy/done handshake to the surrounding datapath.

Parameters:
N, 4, chunk width = width of the shared adder instance
K, 4, number of chunks per operation; K >= 2
W, N*K, operand/result width (localparam, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request new addition; sampled only when not busy
A  input  W  operand A; sampled on accepted start
B  input  W  operand B; sampled on accepted start
Cin  input  1  initial carry-in; sampled on accepted start
busy  output  1  high while chunks are being added
done  output  1  one-cycle pulse; S/Cout valid
S  output  W  sum, held until next accepted start
Cout  output  1  final carry-out, held with S

Behaviour:
- Interface fixed: one clock (clk), synchronous active-high reset (rst).
- Reset: state=IDLE, busy=0, done=0, S=0, Cout=0, internal operand/carry/counter regs=0.
- States: IDLE, SOMA, FIM.
- IDLE: start=1 -> latch A,B into shift regs, carry_reg<=Cin, cnt<=0, go SOMA. start=0 -> stay.
- SOMA (busy=1): adder inputs = A_reg[N-1:0], B_reg[N-1:0], carry_reg. Each cycle: A_reg/B_reg shift right by N; S_reg shifts right by N with adder sum entering S_reg[W-1:W-N]; carry_reg<=adder Cout; cnt++. When cnt==K-1 (last chunk) -> go FIM.
- FIM: done=1 for exactly this cycle, busy=0; S=S_reg, Cout=carry_reg. Next state IDLE; start=1 in FIM is accepted as in IDLE (back-to-back, no bubble).
- Latency: start accepted at edge t -> busy from t+1 for K cycles -> done high during cycle t+K+1. Throughput: one op per K+1 cycles.
- start while in SOMA: ignored, no effect on in-flight operation or latched operands.
- A/B/Cin changes after acceptance: no effect.
- S/Cout update only on entry to FIM; stable otherwise (including IDLE).
- Wrap-around: sum is modulo 2^W; overflow beyond W bits appears only in Cout.
- rst asserted in any state (mid-operation included): next cycle is reset state; partial result discarded, no done pulse.
- rst and start together: rst wins.

Optional Feature:
SOMADOR_OVF_EN: when defined, extra output V (1 bit) = signed two's-complement overflow = carry into bit W-1 XOR Cout, captured alongside Cout on entry to FIM, reset to 0, held until next result. Without the macro, port V and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (IDLE, SOMA, FIM), state width.
- Sub-module: existing somador_completo_nbits #(N), one instance, reused every cycle. No new sub-module; counter width = clog2(K).

Test Plan:
- N=4,K=4: A=16'h00FF, B=16'h0001, Cin=0, start pulse -> busy 4 cycles, done in cycle 5 after start, S=16'h0100, Cout=0.
- A=16'hFFFF, B=16'h0001, Cin=0 -> S=16'h0000, Cout=1; carry ripples across all 4 chunks.
- A=16'hFFFF, B=16'hFFFF, Cin=1 -> S=16'hFFFF, Cout=1; then start held high in FIM with A=1, B=2 -> second done K+1 cycles later, S=16'h0003.
- start A=16'h1234, B=16'h1111; re-pulse start at cycle 2 with A=B=16'hFFFF -> ignored; S=16'h2345, single done pulse.
- rst at cycle 2 of SOMA -> next cycle busy=0, done=0, S=0, Cout=0, no done pulse; fresh start A=5, B=8 -> S=16'h000D.
- With SOMADOR_OVF_EN: A=16'h7FFF, B=16'h0001 -> S=16'h8000, Cout=0, V=1; A=16'hFFFF, B=16'h0001 -> V=0.
